// File: rtl/inst_fetch_pkg.sv
// Shared CPU constants and types for the instruction-fetch slice.
// Optional feature macro: INST_FETCH_NOP_EN (present a NOP while no instruction is valid).
package inst_fetch_pkg;
  localparam int unsigned PC_W = 64;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 64'h0;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t ST_RUN  = 1'b0;
  localparam fetch_state_t ST_HALT = 1'b1;

  function automatic logic misaligned(input logic [PC_W-1:0] a);
    return a[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request bus between fetch (master) and memory (slave).
interface inst_fetch_if;
  import inst_fetch_pkg::*;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/inst_fetch_pc_next.sv
// Next fetch-PC selection: aligned redirect > stall hold > sequential +4 on handshake.
module pc_next
  import inst_fetch_pkg::*;
(
  input  logic [PC_W-1:0] pc_f,
  input  logic            hs,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc_nxt
);
  always_comb begin
    pc_nxt = pc_f;
    if (redirect) begin
      // a misaligned target halts fetch, so the old PC is kept
      if (!misaligned(redirect_pc)) pc_nxt = redirect_pc;
    end else if (!stall && hs) begin
      pc_nxt = pc_f + 64'd4;
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// Single-issue instruction fetch with stall, redirect/flush and sticky misalignment halt.
// Optional feature macro: INST_FETCH_NOP_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_if.master      imem,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [31:0]       inst,
  output logic [PC_W-1:0]   pc,
  output logic              inst_valid,
  output logic              flush,
  output logic              fetch_err
);
  fetch_state_t    state_q;
  logic [PC_W-1:0] pc_f, pc_nxt, pc_q;
  logic [31:0]     inst_q;
  logic            vld_q, flush_q, err_q;
  logic            run, redir_run, hs;

  assign run       = (state_q == ST_RUN);
  assign redir_run = run & redirect;

  assign imem.imem_req  = rst & run & ~stall & ~redirect;
  assign imem.imem_addr = pc_f;
  assign hs             = imem.imem_req & imem.imem_ready;

  pc_next u_pc_next (
    .pc_f        (pc_f),
    .hs          (hs),
    .stall       (stall),
    .redirect    (redir_run),
    .redirect_pc (redirect_pc),
    .pc_nxt      (pc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      pc_f    <= RESET_PC;
      pc_q    <= '0;
      inst_q  <= '0;
      vld_q   <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      flush_q <= redir_run;
      pc_f    <= pc_nxt;
      if (redir_run) begin
        vld_q <= 1'b0;
        if (misaligned(redirect_pc)) begin
          state_q <= ST_HALT;
          err_q   <= 1'b1;
        end
      end else if (run && !stall) begin
        vld_q <= hs;
        if (hs) begin
          inst_q <= imem.imem_rdata;
          pc_q   <= pc_f;
        end
      end
    end
  end

`ifdef INST_FETCH_NOP_EN
  assign inst = vld_q ? inst_q : NOP_INST;
`else
  assign inst = inst_q;
`endif
  assign pc         = pc_q;
  assign inst_valid = vld_q;
  assign flush      = flush_q;
  assign fetch_err  = err_q;
endmodule
